// File: rtl/pixel_sink_pkg.sv
// Shared display constants, the output-stage state type and the framebuffer address helper.
package pixel_sink_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 18;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic {
        OUT_EMPTY   = 1'b0,
        OUT_PRESENT = 1'b1
    } out_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // Row-major word address; 119*160+159 = 19199 fits in 15 bits.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int             screen_w
    );
        return ADDR_W'(y) * ADDR_W'(screen_w) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_sink_sync_fifo.sv
// Small synchronous FIFO with a combinational head read so a pop can load the output stage on the same edge.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign pop_ok  = pop && !clear && (count_reg != '0);
    assign push_ok = push && !clear && ((count_reg != (PTR_W+1)'(DEPTH)) || pop_ok);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/pixel_sink.sv
// Buffers pixel writes into a FIFO and drains them to a framebuffer write port with a one-entry output stage.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = pixel_sink_pkg::SCREEN_W,
    parameter int SCREEN_H = pixel_sink_pkg::SCREEN_H
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [pixel_sink_pkg::X_W-1:0]      vga_x,
    input  logic [pixel_sink_pkg::Y_W-1:0]      vga_y,
    input  logic [pixel_sink_pkg::COLOUR_W-1:0] vga_colour,
    input  logic                                vga_write,
    input  logic                                clear,
    output logic [pixel_sink_pkg::ADDR_W-1:0]   fb_addr,
    output logic [pixel_sink_pkg::COLOUR_W-1:0] fb_data,
    output logic                                fb_we,
    input  logic                                fb_ready,
    output logic                                overflow,
    output logic [7:0]                          drop_count,
    output logic                                busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pixel_t              wr_pixel;
    pixel_t              rd_pixel;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic                in_range;
    logic                do_pop;
    logic                do_push;
    logic                drop_pixel;

    out_state_t          state_reg;
    logic [ADDR_W-1:0]   fb_addr_reg;
    logic [COLOUR_W-1:0] fb_data_reg;
    logic                overflow_reg;
    logic [7:0]          drop_count_reg;

    assign in_range = (int'(vga_x) < SCREEN_W) && (int'(vga_y) < SCREEN_H);

    assign wr_pixel.addr   = pixel_addr(vga_x, vga_y, SCREEN_W);
    assign wr_pixel.colour = vga_colour;

    // The output stage refills whenever it is empty or its current pixel is being taken.
    assign do_pop     = !fifo_empty && ((state_reg == OUT_EMPTY) || fb_ready) && !clear;
    assign do_push    = vga_write && !clear && in_range && (!fifo_full || do_pop);
    assign drop_pixel = vga_write && !clear && !do_push;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pixel_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .push    (do_push),
        .pop     (do_pop),
        .wr_data (wr_pixel),
        .rd_data (rd_pixel),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= OUT_EMPTY;
            fb_addr_reg    <= '0;
            fb_data_reg    <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (clear) begin
            state_reg      <= OUT_EMPTY;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (do_pop) begin
                state_reg   <= OUT_PRESENT;
                fb_addr_reg <= rd_pixel.addr;
                fb_data_reg <= rd_pixel.colour;
            end else if ((state_reg == OUT_PRESENT) && fb_ready) begin
                state_reg <= OUT_EMPTY;
            end

            // Off-screen drops count but only a full-storage drop is an overflow.
            if (drop_pixel) begin
                if (drop_count_reg != 8'hFF) begin
                    drop_count_reg <= drop_count_reg + 8'd1;
                end
                if (in_range) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    assign fb_addr    = fb_addr_reg;
    assign fb_data    = fb_data_reg;
    assign fb_we      = (state_reg == OUT_PRESENT);
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;
    assign busy       = (fifo_count != '0) || (state_reg == OUT_PRESENT);

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: queue-based reference model plus directed literal checks and random traffic.
module tb_pixel_sink;

    localparam int DEPTH = 8;
    localparam int SW    = 160;
    localparam int SH    = 120;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;
    logic        clear;
    logic [14:0] fb_addr;
    logic [17:0] fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        busy;

    pixel_sink #(
        .DEPTH    (DEPTH),
        .SCREEN_W (SW),
        .SCREEN_H (SH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_write  (vga_write),
        .clear      (clear),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .overflow   (overflow),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every stored pixel in one queue, front is the presented one when m_valid.
    typedef struct packed {
        logic [14:0] a;
        logic [17:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_valid = 1'b0;
    bit   m_ovf   = 1'b0;
    int   m_drop  = 0;

    always @(posedge clock or posedge reset) begin : model
        int n;
        if (reset || clear) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_drop  = 0;
        end else begin
            if (m_valid && fb_ready) begin
                void'(mq.pop_front());
            end
            n = mq.size();
            if (vga_write) begin
                if (int'(vga_x) >= SW || int'(vga_y) >= SH) begin
                    if (m_drop < 255) m_drop++;
                end else if (n < DEPTH + 1) begin
                    mq.push_back('{a: 15'(int'(vga_y) * SW + int'(vga_x)), d: vga_colour});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            m_valid = (n > 0);
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            chk("m_fb_we", fb_we, m_valid);
            if (m_valid) begin
                chk("m_fb_addr", fb_addr, mq[0].a);
                chk("m_fb_data", fb_data, mq[0].d);
            end
            chk("m_overflow", overflow, m_ovf);
            chk("m_drop_count", drop_count, m_drop);
            chk("m_busy", busy, mq.size() > 0);
        end
    end

    task automatic wr(input int x, input int y, input int c);
        vga_write  = 1'b1;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 18'(c);
    endtask

    task automatic idle();
        vga_write = 1'b0;
    endtask

    task automatic nclk();
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int pr [4] = '{90, 50, 20, 100};

        reset = 1'b1; clear = 1'b0; vga_write = 1'b0;
        vga_x = '0; vga_y = '0; vga_colour = '0; fb_ready = 1'b1;
        #1;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_busy", busy, 0);
        nclk(); nclk();
        #2 reset = 1'b0;
        nclk();
        cmp_en = 1'b1;

        // Single pixel latency and one-cycle presentation.
        wr(5, 2, 'h3FFFF);
        nclk(); idle();
        chk("lat_edge_n", fb_we, 0);
        nclk();
        chk("lat_edge_n1_we", fb_we, 1);
        chk("lat_addr", fb_addr, 325);
        chk("lat_data", fb_data, 'h3FFFF);
        nclk();
        chk("lat_one_cycle", fb_we, 0);

        // Off-screen drop, then bottom-right corner.
        wr(160, 0, 1);
        nclk(); idle(); nclk();
        chk("oob_drop", drop_count, 1);
        chk("oob_ovf", overflow, 0);
        chk("oob_we", fb_we, 0);
        wr(159, 119, 'h12345);
        nclk(); idle(); nclk();
        chk("corner_we", fb_we, 1);
        chk("corner_addr", fb_addr, 19199);
        nclk();

        // Backpressure: 10 writes into DEPTH+1 storage.
        clear = 1'b1; nclk(); clear = 1'b0;
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr(i, 1, i + 100);
            nclk();
        end
        idle();
        chk("bp_ovf", overflow, 1);
        chk("bp_drop", drop_count, 1);
        chk("bp_busy", busy, 1);
        fb_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("bp_drain_we", fb_we, 1);
            chk("bp_drain_addr", fb_addr, 160 + k);
            chk("bp_drain_data", fb_data, 100 + k);
            nclk();
        end
        chk("bp_drain_end", fb_we, 0);
        chk("bp_idle_busy", busy, 0);

        // Clear together with an in-range write while overflowed.
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr(i, 3, i);
            nclk();
        end
        idle();
        chk("clr_pre_ovf", overflow, 1);
        clear = 1'b1;
        wr(3, 3, 7);
        nclk();
        clear = 1'b0; idle();
        chk("clr_busy", busy, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_count, 0);
        chk("clr_we", fb_we, 0);
        fb_ready = 1'b1;
        nclk();
        chk("clr_we_after", fb_we, 0);

        // Saturation of drop_count.
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 1) wr(200, 0, i);
            else            wr(10, 125, i);
            nclk();
        end
        idle();
        chk("sat_255", drop_count, 255);
        chk("sat_ovf", overflow, 0);
        for (int i = 0; i < 5; i++) begin
            wr(170, 0, 0);
            nclk();
        end
        idle();
        chk("sat_hold", drop_count, 255);
        clear = 1'b1; nclk(); clear = 1'b0;

        // Reset in the middle of a transfer.
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(20 + i, 5, i);
            nclk();
        end
        idle(); nclk();
        chk("mid_we", fb_we, 1);
        chk("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_we", fb_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", fb_addr, 0);
        chk("arst_data", fb_data, 0);
        nclk(); nclk();
        #2 reset = 1'b0;
        fb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nclk();
            chk("post_rst_we", fb_we, 0);
        end

        // Random traffic with varying framebuffer readiness.
        for (int seg = 0; seg < 4; seg++) begin
            for (int cyc = 0; cyc < 500; cyc++) begin
                fb_ready = ($urandom_range(0, 99) < pr[seg]);
                if ($urandom_range(0, 3) != 0)
                    wr($urandom_range(0, 170), $urandom_range(0, 127), $urandom);
                else
                    idle();
                clear = ($urandom_range(0, 149) == 0);
                nclk();
            end
        end
        idle(); clear = 1'b0; fb_ready = 1'b1;
        repeat (12) nclk();
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter DEPTH, 8, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter SCREEN_W, 160, visible pixel columns.
REQ-003 Parameter SCREEN_H, 120, visible pixel rows.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 vga_x  in  8  pixel column from the pixel writer.
REQ-007 vga_y  in  7  pixel row from the pixel writer.
REQ-008 vga_colour  in  18  pixel colour, 6:6:6.
REQ-009 vga_write  in  1  pixel-write strobe; one pixel per cycle while high, with no backpressure to the writer.
REQ-010 clear  in  1  synchronous flush of the FIFO, output stage, overflow and drop_count.
REQ-011 fb_addr  out  15  framebuffer word address.
REQ-012 fb_data  out  18  framebuffer write data.
REQ-013 fb_we  out  1  framebuffer write valid.
REQ-014 fb_ready  in  1  framebuffer accepts the write this cycle when high with fb_we high.
REQ-015 overflow  out  1  sticky flag: a pixel was dropped because storage was full.
REQ-016 drop_count  out  8  saturating count of all dropped pixels.
REQ-017 busy  out  1  high while the FIFO or the output stage holds data.

Function
REQ-018 Enqueue address SHALL be vga_y*SCREEN_W + vga_x, computed at acceptance, 15 bits, no truncation for in-range inputs.
REQ-019 Write with vga_x>=SCREEN_W or vga_y>=SCREEN_H SHALL be discarded and increment drop_count, without setting overflow.
REQ-020 Output stage has two states: EMPTY (fb_we=0) and PRESENT (fb_we=1).
REQ-021 A pop from the FIFO SHALL occur when count>0 and (state is EMPTY or fb_ready=1); popped entry loads fb_addr/fb_data and state becomes PRESENT.
REQ-022 PRESENT with fb_ready=1 and no pop SHALL go to EMPTY; PRESENT with fb_ready=0 SHALL hold fb_addr/fb_data/fb_we unchanged.
REQ-023 In-range write SHALL be pushed if count<DEPTH or a pop occurs in the same cycle; otherwise it is dropped, overflow is set and drop_count increments.
REQ-024 Total storage is DEPTH+1 pixels (FIFO plus output stage); pixels reach the framebuffer in acceptance order.
REQ-025 Latency: a pixel accepted into an empty sink at edge N SHALL present fb_we=1 after edge N+1.
REQ-026 Sustained throughput SHALL be one pixel per cycle while fb_ready=1.
REQ-027 drop_count SHALL saturate at 255, never wrap.
REQ-028 clear SHALL empty the FIFO, set the output stage to EMPTY, and zero overflow and drop_count at the next edge; a vga_write in the same cycle is discarded and not counted.
REQ-029 busy = (count!=0) or state is PRESENT.

Reset
REQ-030 Reset SHALL act immediately without a clock edge and set fb_we=0, fb_addr=0, fb_data=0, overflow=0, drop_count=0, busy=0, FIFO pointers and count=0, state EMPTY.
REQ-031 Reset mid-transfer SHALL abandon the presented and queued pixels; none SHALL appear after reset release.

Structure
REQ-032 SCREEN_W, SCREEN_H, address width (15) and colour width (18) SHALL live in the shared display constants package.
REQ-033 Storage SHALL be one sub-module, sync_fifo, with push/pop/count/full/empty and a DEPTH parameter; pixel_sink holds address computation, drop logic and the output stage.

Verification
REQ-034 x=5, y=2, colour=0x3FFFF, fb_ready=1 -> fb_we high for exactly one cycle after edge N+1, fb_addr=325, fb_data=0x3FFFF.
REQ-035 x=160, y=0 write -> no fb_we, drop_count=1, overflow=0; x=159, y=119 -> fb_addr=19199.
REQ-036 fb_ready=0, 10 consecutive in-range writes (DEPTH=8) -> 9 stored, overflow=1, drop_count=1; then fb_ready=1 -> 9 fb_we cycles back-to-back, in order.
REQ-037 300 out-of-range writes -> drop_count=255 and held there.
REQ-038 Reset asserted while fb_we=1 with queued data -> fb_we=0 before the next edge, busy=0, no writes after release.
REQ-039 clear and an in-range vga_write in the same cycle with overflow=1 -> next cycle busy=0, overflow=0, drop_count=0, no fb_we.
